mem_arbiter: RTL and testbench

Two-port memory arbiter between the instruction-side and data-side cache management units and a single shared backing RAM. It accepts word transactions (cs/we/addr/data with ack) from both CMUs and grants exactly one of them the backing memory at a time. A grant is held for the whole transaction burst, such as a cache-line refill or write-back. Ties are resolved round-robin. Per-port completed-word counters are exported for the debug display.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
// Grant states and port identifiers used by the FSM and the debug counters.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_e;

    localparam logic ARB_PORT_I = 1'b0;
    localparam logic ARB_PORT_D = 1'b1;

    localparam int DATA_WIDTH = 32;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the I-CMU or D-CMU exclusive use of the shared RAM.
// A grant is held for as long as the owner keeps cs high, so line bursts stay whole.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_cs_i,
    input  logic                  i_we_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    input  logic [DATA_WIDTH-1:0] i_data_i,
    output logic [DATA_WIDTH-1:0] i_data_o,
    output logic                  i_ack_o,

    input  logic                  d_cs_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_data_i,
    output logic [DATA_WIDTH-1:0] d_data_o,
    output logic                  d_ack_o,

    output logic                  mem_cs_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack_i,

    output logic [CNT_WIDTH-1:0]  i_cnt_o,
    output logic [CNT_WIDTH-1:0]  d_cnt_o
);

    arb_state_e           state_q, state_d;
    logic                 last_q, last_d;
    logic [CNT_WIDTH-1:0] i_cnt_q, i_cnt_d;
    logic [CNT_WIDTH-1:0] d_cnt_q, d_cnt_d;
    logic                 gnt_i, gnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            last_q  <= ARB_PORT_I;
            i_cnt_q <= '0;
            d_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            i_cnt_q <= i_cnt_d;
            d_cnt_q <= d_cnt_d;
        end
    end

    // Release hands straight over to a waiting port, avoiding an IDLE bubble.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (i_cs_i && d_cs_i) begin
                    state_d = (last_q == ARB_PORT_I) ? ARB_GNT_D : ARB_GNT_I;
                end else if (i_cs_i) begin
                    state_d = ARB_GNT_I;
                end else if (d_cs_i) begin
                    state_d = ARB_GNT_D;
                end
            end
            ARB_GNT_I: begin
                if (!i_cs_i) begin
                    last_d  = ARB_PORT_I;
                    state_d = d_cs_i ? ARB_GNT_D : ARB_IDLE;
                end
            end
            ARB_GNT_D: begin
                if (!d_cs_i) begin
                    last_d  = ARB_PORT_D;
                    state_d = i_cs_i ? ARB_GNT_I : ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign gnt_i = (state_q == ARB_GNT_I);
    assign gnt_d = (state_q == ARB_GNT_D);

    always_comb begin
        mem_cs_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        if (gnt_i) begin
            mem_cs_o   = i_cs_i;
            mem_we_o   = i_we_i;
            mem_addr_o = i_addr_i;
            mem_data_o = i_data_i;
        end else if (gnt_d) begin
            mem_cs_o   = d_cs_i;
            mem_we_o   = d_we_i;
            mem_addr_o = d_addr_i;
            mem_data_o = d_data_i;
        end
    end

    // A late RAM ack after the owner dropped cs must not reach either CMU.
    assign i_ack_o  = mem_ack_i & gnt_i & i_cs_i & ~rst;
    assign d_ack_o  = mem_ack_i & gnt_d & d_cs_i & ~rst;
    assign i_data_o = gnt_i ? mem_data_i : '0;
    assign d_data_o = gnt_d ? mem_data_i : '0;

    assign i_cnt_d = i_cnt_q + {{(CNT_WIDTH-1){1'b0}}, i_ack_o};
    assign d_cnt_d = d_cnt_q + {{(CNT_WIDTH-1){1'b0}}, d_ack_o};
    assign i_cnt_o = i_cnt_q;
    assign d_cnt_o = d_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: CMU burst drivers push expected words,
// a monitor pops and compares on every forwarded ack.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int CW = 4;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] exp;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_cs, i_we, d_cs, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [31:0]   i_wdata, d_wdata, i_rdata, d_rdata;
    logic          i_ack, d_ack;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_ack;
    logic [CW-1:0] i_cnt, d_cnt;

    mem_arbiter #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .i_cs_i(i_cs), .i_we_i(i_we), .i_addr_i(i_addr), .i_data_i(i_wdata),
        .i_data_o(i_rdata), .i_ack_o(i_ack),
        .d_cs_i(d_cs), .d_we_i(d_we), .d_addr_i(d_addr), .d_data_i(d_wdata),
        .d_data_o(d_rdata), .d_ack_o(d_ack),
        .mem_cs_o(mem_cs), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
        .i_cnt_o(i_cnt), .d_cnt_o(d_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int icount = 0;
    int dcount = 0;
    int lat = 8;
    logic force_ack = 1'b0;
    txn_t iq[$];
    txn_t dq[$];
    logic [31:0] shadow [0:4095];

    function automatic logic [31:0] init_val(input int k);
        return 32'hA5C3_0000 | 32'(k);
    endfunction

    // Backing RAM model: ack after 'lat' cycles of continuous cs, one-cycle pulse.
    logic [31:0] ram [0:4095];
    bit          ram_ready = 1'b0;
    logic        ram_ack_q = 1'b0;
    int          ram_cnt = 0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int k = 0; k < 4096; k++) ram[k] <= init_val(k);
            ram_ready <= 1'b1;
        end else if (ram_ack_q) begin
            ram_ack_q <= 1'b0;
            ram_cnt   <= 0;
        end else if (mem_cs) begin
            if (ram_cnt + 1 >= lat) begin
                ram_ack_q <= 1'b1;
                if (mem_we) ram[mem_addr[13:2]] <= mem_wdata;
            end else begin
                ram_cnt <= ram_cnt + 1;
            end
        end else begin
            ram_cnt <= 0;
        end
    end

    assign mem_rdata = ram_ack_q ? ram[mem_addr[13:2]] : 32'h0;
    assign mem_ack   = ram_ack_q | force_ack;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit p, input logic cs, input logic we,
                         input logic [31:0] a, input logic [31:0] dt);
        if (p == 1'b0) begin
            i_cs = cs; i_we = we; i_addr = a; i_wdata = dt;
        end else begin
            d_cs = cs; d_we = we; d_addr = a; d_wdata = dt;
        end
    endtask

    task automatic check_ack(input bit p);
        txn_t t;
        if ((p ? dq.size() : iq.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ack port %0d: got ack expected none", p);
            return;
        end
        t = p ? dq.pop_front() : iq.pop_front();
        chk(p ? "d_ack_addr" : "i_ack_addr", mem_addr, t.addr);
        chk(p ? "d_ack_cs" : "i_ack_cs", 32'(p ? d_cs : i_cs), 32'd1);
        chk("ack_exclusive", 32'(p ? i_ack : d_ack), 32'd0);
        if (t.we) chk(p ? "d_wdata" : "i_wdata", mem_wdata, t.exp);
        else      chk(p ? "d_rdata" : "i_rdata", p ? d_rdata : i_rdata, t.exp);
    endtask

    always @(negedge clk) begin
        if (i_ack === 1'b1) check_ack(1'b0);
        if (d_ack === 1'b1) check_ack(1'b1);
    end

    task automatic wait_ack(input bit p);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((p ? d_ack : i_ack) !== 1'b1 && t < 400);
        if ((p ? d_ack : i_ack) !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout port %0d: got no ack expected ack", p);
        end
    endtask

    task automatic burst(input bit p, input logic [31:0] base, input int n,
                         input bit we);
        logic [31:0] a;
        logic [31:0] dt;
        txn_t t;
        for (int w = 0; w < n; w++) begin
            a = base + 32'(4 * w);
            dt = $urandom;
            t.we = we;
            t.addr = a;
            t.exp = we ? dt : shadow[a[13:2]];
            if (we) shadow[a[13:2]] = dt;
            if (p) begin dq.push_back(t); dcount++; end
            else   begin iq.push_back(t); icount++; end
            drive(p, 1'b1, we, a, dt);
            wait_ack(p);
            @(posedge clk); #1;
        end
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic chk_counts(input string name);
        chk({name, "_icnt"}, 32'(i_cnt), 32'(icount % 16));
        chk({name, "_dcnt"}, 32'(d_cnt), 32'(dcount % 16));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_last;
        bit winner;
        int saved;
        for (int k = 0; k < 4096; k++) shadow[k] = init_val(k);

        // Reset with both requesters active.
        drive(0, 1'b1, 1'b0, 32'h200, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h40, 32'h0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_mem_cs", 32'(mem_cs), 32'd0);
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_acks", 32'({i_ack, d_ack}), 32'd0);
            chk("rst_rdata", i_rdata | d_rdata, 32'h0);
            chk("rst_cnts", 32'({i_cnt, d_cnt}), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_tie_cs", 32'(mem_cs), 32'd1);
        chk("first_tie_to_d", mem_addr, 32'h40);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Solo instruction line refill.
        lat = 8;
        burst(0, 32'h100, 4, 1'b0);
        chk_counts("solo");

        // Data CMU arrives mid-burst and must wait, then take over with no bubble.
        fork
            burst(0, 32'h110, 6, 1'b0);
            begin
                repeat (5) @(posedge clk);
                #1;
                burst(1, 32'h1000, 3, 1'b1);
            end
            begin
                int t = 0;
                @(negedge clk);
                while (i_cs && t < 1000) begin
                    @(negedge clk);
                    t++;
                end
                @(negedge clk);
                chk("handover_cs", 32'(mem_cs), 32'd1);
                chk("handover_addr", mem_addr, 32'h1000);
                chk("handover_we", 32'(mem_we), 32'd1);
            end
        join
        burst(1, 32'h1000, 3, 1'b0);
        chk_counts("contention");

        // Counter wrap: 17 acks from zero leaves 1 in a 4-bit counter.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        icount = 0;
        dcount = 0;
        lat = 1;
        burst(0, 32'h200, 17, 1'b0);
        chk("wrap_icnt", 32'(i_cnt), 32'd1);

        // Reset in the middle of a granted access.
        lat = 8;
        drive(0, 1'b1, 1'b0, 32'h300, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        chk("ack_during_rst", 32'(i_ack), 32'd0);
        @(negedge clk);
        chk("rst_midburst_cs", 32'(mem_cs), 32'd0);
        chk("rst_midburst_icnt", 32'(i_cnt), 32'd0);
        rst = 1'b0;
        force_ack = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        icount = 0;
        dcount = 0;
        exp_last = 1'b0;
        @(posedge clk); #1;

        // Round-robin on simultaneous requests from IDLE.
        for (int r = 0; r < 4; r++) begin
            winner = ~exp_last;
            drive(0, 1'b1, 1'b0, 32'h400, 32'h0);
            drive(1, 1'b1, 1'b0, 32'h1400, 32'h0);
            @(posedge clk);
            @(negedge clk);
            chk("rr_cs", 32'(mem_cs), 32'd1);
            chk("rr_winner", mem_addr, winner ? 32'h1400 : 32'h400);
            drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
            exp_last = winner;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end

        // Abort: D drops cs early; a late RAM ack must be swallowed.
        saved = dcount;
        drive(1, 1'b1, 1'b0, 32'h1800, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        force_ack = 1'b1;
        @(negedge clk);
        chk("abort_ack_cs_low", 32'({i_ack, d_ack}), 32'd0);
        @(negedge clk);
        chk("abort_left_gnt", 32'(mem_cs), 32'd0);
        chk("abort_late_ack", 32'({i_ack, d_ack}), 32'd0);
        @(posedge clk); #1;
        force_ack = 1'b0;
        chk("abort_dcnt", 32'(d_cnt), 32'(saved % 16));

        // Randomized concurrent bursts with varying RAM latency.
        for (int it = 0; it < 20; it++) begin
            int ni, nd, di, dd;
            bit wi, wd;
            logic [31:0] bi, bd;
            lat = $urandom_range(1, 8);
            ni = $urandom_range(1, 4);
            nd = $urandom_range(1, 4);
            wi = 1'($urandom_range(0, 1));
            wd = 1'($urandom_range(0, 1));
            bi = 32'h100 + 32'($urandom_range(0, 15)) * 32'h20;
            bd = 32'h1000 + 32'($urandom_range(0, 15)) * 32'h20;
            di = $urandom_range(0, 6);
            dd = $urandom_range(0, 6);
            fork
                begin
                    repeat (di) @(posedge clk);
                    #1;
                    burst(0, bi, ni, wi);
                end
                begin
                    repeat (dd) @(posedge clk);
                    #1;
                    burst(1, bd, nd, wd);
                end
            join
        end
        chk_counts("random");
        chk("iq_drained", 32'(iq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
